// File: rtl/addsub_operand_fifo.sv
// Operand FIFO feeding a downstream adder-subtractor: stores {a, b, s} sets and
// presents the head first-word-fall-through, zeroed while empty.
module addsub_operand_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   input  logic                     in_s,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_a,
   output logic [WIDTH-1:0]         out_b,
   output logic                     out_s,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = 2 * WIDTH + 1;

   // Pointer wrap relies on DEPTH being a power of two.
   if (DEPTH != 2 && DEPTH != 4 && DEPTH != 8) begin : g_bad_depth
      $error("addsub_operand_fifo: DEPTH must be 2, 4 or 8");
   end

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   cnt_q;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] head;

   // Handshake flags come from the registered count only.
   assign in_ready  = (cnt_q != CNT_W'(DEPTH));
   assign out_valid = (cnt_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Storage needs no reset: it is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_a, in_b, in_s};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else if (pop && !push) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   always_comb begin
      head = '0;
      if (out_valid) begin
         head = mem[rd_ptr];
      end
   end

   assign {out_a, out_b, out_s} = head;
   assign count                 = cnt_q;

endmodule

// File: tb/tb_addsub_operand_fifo.sv
// Scoreboard bench for addsub_operand_fifo: a queue of expected entries is
// pushed on accepted stimulus and popped as the DUT hands entries downstream.
module tb_addsub_operand_fifo;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned WIDTH = 64;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             s;
   } ent_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_s;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic             out_s;
   logic [2:0]       count;

   ent_t q[$];
   int   n_checks;
   int   n_pass;

   addsub_operand_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_s      (in_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_s     (out_s),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Compare every visible output against the scoreboard head.
   task automatic check_outputs(input string tag);
      ent_t h;
      h = '0;
      if (q.size() != 0) h = q[0];
      check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
      check({tag, ".in_ready"},  64'(in_ready),  64'(q.size() != DEPTH));
      check({tag, ".count"},     64'(count),     64'(q.size()));
      check({tag, ".out_a"},     out_a,          h.a);
      check({tag, ".out_b"},     out_b,          h.b);
      check({tag, ".out_s"},     64'(out_s),     64'(h.s));
   endtask

   // One clock: drive inputs, check outputs, advance the scoreboard on the edge.
   task automatic step(input string tag, input logic v, input logic [63:0] a,
                       input logic [63:0] b, input logic s, input logic rdy);
      ent_t e;
      logic push;
      logic pop;
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_s      = s;
      out_ready = rdy;
      #1;
      check_outputs(tag);
      push = v && (q.size() != DEPTH);
      pop  = rdy && (q.size() != 0);
      @(posedge clk);
      if (pop) e = q.pop_front();
      if (push) q.push_back('{a: a, b: b, s: s});
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) begin
         step(tag, 1'b0, '0, '0, 1'b0, 1'b1);
      end
      #1;
      check({tag, ".empty"}, 64'(count), 64'd0);
   endtask

   initial begin
      logic [63:0] sum;
      n_checks  = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_s      = 1'b0;
      out_ready = 1'b0;

      // Reset held for three cycles, then released.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check_outputs("rst_hold");
      end
      rst_n = 1'b1;
      #1;
      check_outputs("rst_idle");
      @(negedge clk);

      // Single subtract entry: 5 - 3.
      step("single", 1'b1, 64'h5, 64'h3, 1'b1, 1'b0);
      #1;
      check("single.count", 64'(count), 64'd1);
      check("single.out_a", out_a, 64'h5);
      sum = out_s ? out_a - out_b : out_a + out_b;
      check("single.result", sum, 64'd2);
      step("single_pop", 1'b0, '0, '0, 1'b0, 1'b1);
      #1;
      check("single.empty_a", out_a, 64'd0);
      check("single.empty_v", 64'(out_valid), 64'd0);

      // Fill to full, attempt a fifth push, then drain in order.
      for (int i = 1; i <= 4; i++) begin
         step("fill", 1'b1, 64'(i), 64'(i * 16), 1'(i), 1'b0);
      end
      #1;
      check("fill.count", 64'(count), 64'd4);
      check("fill.in_ready", 64'(in_ready), 64'd0);
      step("fill_blocked", 1'b1, 64'h5, 64'h50, 1'b1, 1'b0);
      #1;
      check("fill.still_head1", out_a, 64'h1);
      drain("fill_drain");

      // Full with in_valid and out_ready together: only the pop happens.
      for (int i = 0; i < 4; i++) begin
         step("full2", 1'b1, 64'h100 + 64'(i), 64'(i), 1'b0, 1'b0);
      end
      step("full_pop", 1'b1, 64'h999, 64'h1, 1'b1, 1'b1);
      #1;
      check("full_pop.count", 64'(count), 64'd3);
      check("full_pop.in_ready", 64'(in_ready), 64'd1);
      check("full_pop.head", out_a, 64'h101);
      drain("full_drain");

      // Streaming through pointer wrap with the FIFO kept at one entry.
      for (int i = 0; i < 10; i++) begin
         step("stream", 1'b1, 64'hFFFF_FFFF_FFFF_FFF0 + 64'(i), ~64'(i), 1'(i), 1'b1);
         #1;
         check("stream.count", 64'(count), 64'd1);
      end
      drain("stream_drain");

      // Asynchronous reset mid-operation discards stored entries.
      for (int i = 0; i < 3; i++) begin
         step("pre_rst", 1'b1, 64'h200 + 64'(i), 64'h7, 1'b0, 1'b0);
      end
      rst_n = 1'b0;
      #1;
      q.delete();
      check("midrst.count", 64'(count), 64'd0);
      check("midrst.out_valid", 64'(out_valid), 64'd0);
      check("midrst.out_a", out_a, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 1'b1, 64'hAA, 64'h55, 1'b0, 1'b0);
      #1;
      check("post_rst.head", out_a, 64'hAA);
      drain("post_rst_drain");

      // Random traffic against the scoreboard.
      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom_range(0, 1)), {$urandom, $urandom},
              {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0));
      end
      drain("rand_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/addsub_operand_fifo.md
ADDSUB_OPERAND_FIFO -- requirements
Module: addsub_operand_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of operand entries; legal values 2, 4, 8.
REQ-002 SHALL have parameter WIDTH, default 64, operand width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  producer presents an operand set.
REQ-006 SHALL have port in_ready  output  1  FIFO accepts an operand set this cycle.
REQ-007 SHALL have port in_a  input  WIDTH  operand A.
REQ-008 SHALL have port in_b  input  WIDTH  operand B.
REQ-009 SHALL have port in_s  input  1  operation select, 0 = add, 1 = subtract.
REQ-010 SHALL have port out_valid  output  1  head entry present on out_a/out_b/out_s.
REQ-011 SHALL have port out_ready  input  1  downstream 64-bit adder-subtractor consumes head entry.
REQ-012 SHALL have port out_a  output  WIDTH  head operand A, drives adder-subtractor A.
REQ-013 SHALL have port out_b  output  WIDTH  head operand B, drives adder-subtractor B.
REQ-014 SHALL have port out_s  output  1  head select, drives adder-subtractor S.
REQ-015 SHALL have port count  output  log2(DEPTH)+1  number of stored entries.

Function
REQ-016 Push SHALL occur on a rising edge where in_valid && in_ready; entry {in_a, in_b, in_s} written at write pointer.
REQ-017 Pop SHALL occur on a rising edge where out_valid && out_ready; read pointer advances.
REQ-018 in_ready SHALL equal (count != DEPTH), derived from registered state only, independent of in_valid and out_ready.
REQ-019 out_valid SHALL equal (count != 0), derived from registered state only.
REQ-020 Outputs SHALL be first-word-fall-through: head entry visible on out_a/out_b/out_s combinationally from storage at read pointer whenever out_valid = 1.
REQ-021 When count = 0, out_a, out_b, out_s SHALL be driven to 0.
REQ-022 Write-to-output latency SHALL be one cycle: entry pushed into an empty FIFO at edge N gives out_valid = 1 after edge N; no same-cycle bypass.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Push and pop on same edge with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-025 count = DEPTH: in_ready = 0, no push even if pop occurs same edge; count becomes DEPTH-1 after pop.
REQ-026 count = 0: no pop even if out_ready = 1; a push on that edge gives count = 1.
REQ-027 in_valid with in_ready = 0 SHALL not change state; producer holds data (not checked by FIFO).
REQ-028 While out_valid = 1 and out_ready = 0, out_a/out_b/out_s SHALL remain stable, including across a simultaneous push.
REQ-029 Entries SHALL be delivered in push order with no loss, duplication or bit alteration.

Reset
REQ-030 rst_n = 0 SHALL immediately, independent of clk, clear read pointer, write pointer and count to 0.
REQ-031 During and after reset: out_valid = 0, in_ready = 1, count = 0, out_a = out_b = 0, out_s = 0.
REQ-032 Storage array contents SHALL not require reset; they are never observable while count = 0.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries; first push after deassertion appears as head.

Verification
REQ-034 Reset then idle: rst_n low 3 cycles, released -> out_valid = 0, in_ready = 1, count = 0, out_a = out_b = 0, out_s = 0.
REQ-035 Single push: A=64'h0000_0000_0000_0005, B=64'h3, S=1 at edge 1 -> after edge 1 out_valid = 1, out_a = 5, out_b = 3, out_s = 1, count = 1; downstream Out = 2; pop at edge 2 -> count = 0, outputs 0.
REQ-036 Fill and block: 4 pushes (A = 1..4), out_ready = 0 -> count = 4, in_ready = 0; fifth push with A = 5 ignored; drain yields A = 1,2,3,4 in order.
REQ-037 Full with simultaneous in_valid and pop: count = 4, in_valid = 1, out_ready = 1 -> one pop only, count = 3, in_ready = 1 next cycle.
REQ-038 Wrap-around streaming: in_valid = out_ready = 1 for 10 cycles, A = 64'hFFFF_FFFF_FFFF_FFF0 + i -> count stays 1 after first push, outputs in order through pointer wrap.
REQ-039 Reset mid-operation: count = 3, pull rst_n low between edges -> count = 0, out_valid = 0 before next edge; next push A = 64'hAA is head.
